seq_code_lock: RTL and testbench
================================

Name: seq_code_lock

Overview:
Parametrised serial code lock: the next generation of the fixed 3-bit Mealy lock FSM. It compares a bit-serial entry (qualified by a valid strobe) against a CODE_LEN-bit code and opens for a timed window on a match. It counts failed attempts and raises a timed alarm lockout after MAX_FAIL consecutive failures. It sits between a keypad/serial front end and the door actuator/alarm driver.

Parameters:
CODE_LEN, 4, number of bits per code entry (>=2).
CODE, 4'b0110, unlock code, CODE_LEN bits wide, entered MSB first.
MAX_FAIL, 3, consecutive failed attempts that trigger lockout (>=1).
LOCKOUT_CYC, 16, clk cycles the alarm/lockout lasts (>=1).
UNLOCK_CYC, 8, clk cycles the lock stays open after a match (>=1).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset, synchronous, active-high.
bit_valid  in  1  qualifies bit_in this cycle.
bit_in  in  1  serial code bit.
clear  in  1  abort current entry / relock early.
unlocked  out  1  lock open (registered).
alarm  out  1  lockout alarm active (registered).
bad_code  out  1  one-cycle pulse on each failed attempt.
fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures so far.
bit_idx  out  $clog2(CODE_LEN+1)  bits accepted in the current attempt.

Behaviour:
- Reset: clk and rst are already decided as stated (reset rst, synchronous, active-high; clock clk). rst dominates every other input. After reset: state=ENTER, unlocked=0, alarm=0, bad_code=0, fail_cnt=0, bit_idx=0, mismatch flag=0, timers=0.
- State ENTER:
  - Each cycle with bit_valid=1, compare bit_in with CODE[CODE_LEN-1-bit_idx]. OR the result into the mismatch flag and increment bit_idx.
  - No early abort on mismatch: all CODE_LEN bits are always collected, so timing does not leak which bit was wrong.
  - On the cycle the CODE_LEN-th bit is accepted, the attempt is evaluated using the flag including that bit:
    - Match: next cycle state=OPEN, unlocked=1, fail_cnt=0.
    - Mismatch: next cycle bad_code=1 for one cycle and fail_cnt+1.
      - If the new fail_cnt equals MAX_FAIL: state=LOCKOUT, alarm=1.
      - Otherwise stay in ENTER for a new attempt.
  - In all cases bit_idx=0 and the flag is cleared next cycle.
  - clear=1 in ENTER: discard the partial entry (bit_idx=0, flag=0) with no fail increment. clear overrides a same-cycle bit_valid.
- State OPEN:
  - unlocked=1 for exactly UNLOCK_CYC cycles, counted from the first cycle it is high. Then unlocked=0 and state=ENTER.
  - bit_valid is ignored.
  - clear=1 ends OPEN: unlocked=0 the next cycle.
- State LOCKOUT:
  - alarm=1 for exactly LOCKOUT_CYC cycles. bit_valid and clear are ignored.
  - On exit: alarm=0, fail_cnt=0, state=ENTER.
- Output exclusivity: unlocked and alarm are never both 1.
- Latency: a match or lockout appears on outputs 1 cycle after the final bit is accepted.
- Output registering: all outputs come from flops; there is no combinational path from input to output (unlike the previous Mealy version).
- Counter rules:
  - fail_cnt saturates at MAX_FAIL.
  - Timers are sized $clog2(max(LOCKOUT_CYC,UNLOCK_CYC)+1) and reload on state entry.
- Reset mid-operation: rst in any state or mid-entry returns to the reset values on the next edge. An open lock closes and the alarm drops.
- Back-to-back bits: bit_valid may be high every cycle. The first bit of the next attempt is accepted on the cycle right after evaluation while in ENTER.

Test Plan:
1. Correct code: rst, then bits 0,1,1,0 on 4 consecutive cycles -> unlocked=1 one cycle after the 4th bit, held 8 cycles, then 0; fail_cnt=0, alarm=0 throughout.
2. Wrong code: enter 0,1,1,1 -> bad_code single-cycle pulse, fail_cnt=1, unlocked=0. Then enter 0,1,1,0 -> unlocked=1 and fail_cnt returns to 0.
3. Lockout: three wrong entries (1,1,1,1 x3) -> third bad_code pulse with alarm=1 the same cycle, alarm held 16 cycles. Correct code entered during lockout is ignored (unlocked stays 0). After lockout fail_cnt=0, and 0,1,1,0 then unlocks.
4. Gapped entry and clear: bits 0,1 with bit_valid low for 5 cycles between them, then clear=1 together with bit_valid -> bit_idx=0, no bad_code, fail_cnt unchanged. Then 0,1,1,0 unlocks.
5. Early relock and reset mid-op: unlock, assert clear on the 3rd open cycle -> unlocked=0 next cycle. Next, unlock again and assert rst on the 2nd open cycle -> all outputs 0 next cycle. Finally, trigger lockout and assert rst mid-alarm -> alarm=0, fail_cnt=0.
6. Parameter sweep: CODE_LEN=8, CODE=8'hA5, MAX_FAIL=1, UNLOCK_CYC=1 -> 8'hA5 MSB first gives unlocked for exactly 1 cycle. A single wrong 8-bit entry gives immediate lockout.

Source files
------------

// File: rtl/seq_code_lock.sv
// Serial code lock. A bit-serial entry is compared against CODE. A match opens the lock for a
// timed window, and MAX_FAIL consecutive failures raise a timed alarm lockout.
module seq_code_lock #(
    parameter int                  CODE_LEN    = 4,
    parameter logic [CODE_LEN-1:0] CODE        = 4'b0110,
    parameter int                  MAX_FAIL    = 3,
    parameter int                  LOCKOUT_CYC = 16,
    parameter int                  UNLOCK_CYC  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            bit_valid,
    input  logic                            bit_in,
    input  logic                            clear,
    output logic                            unlocked,
    output logic                            alarm,
    output logic                            bad_code,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
    output logic [$clog2(CODE_LEN+1)-1:0]   bit_idx
);

    localparam int IDX_W   = $clog2(CODE_LEN + 1);
    localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
    localparam int TMR_MAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] MAX_FAIL_V  = FAIL_W'(MAX_FAIL);
    localparam logic [TMR_W-1:0]  UNLOCK_LOAD = TMR_W'(UNLOCK_CYC - 1);
    localparam logic [TMR_W-1:0]  LOCK_LOAD   = TMR_W'(LOCKOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_ENTER   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                unlocked_q, unlocked_d;
    logic                alarm_q, alarm_d;
    logic                bad_code_q, bad_code_d;
    logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic                mis_q, mis_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    logic [CODE_LEN-1:0] code_sh;
    logic                mis_now;
    logic [FAIL_W-1:0]   fail_inc;

    always_comb begin
        state_d    = state_q;
        unlocked_d = unlocked_q;
        alarm_d    = alarm_q;
        bad_code_d = 1'b0;
        fail_cnt_d = fail_cnt_q;
        bit_idx_d  = bit_idx_q;
        mis_d      = mis_q;
        timer_d    = timer_q;

        // The expected bit is always the MSB after shifting the code by the bits already taken.
        code_sh  = CODE << bit_idx_q;
        mis_now  = mis_q | (bit_in ^ code_sh[CODE_LEN-1]);
        fail_inc = (fail_cnt_q == MAX_FAIL_V) ? MAX_FAIL_V : fail_cnt_q + FAIL_W'(1);

        case (state_q)
            ST_ENTER: begin
                if (clear) begin
                    bit_idx_d = '0;
                    mis_d     = 1'b0;
                end else if (bit_valid) begin
                    if (bit_idx_q == LAST_IDX) begin
                        bit_idx_d = '0;
                        mis_d     = 1'b0;
                        if (!mis_now) begin
                            state_d    = ST_OPEN;
                            unlocked_d = 1'b1;
                            fail_cnt_d = '0;
                            timer_d    = UNLOCK_LOAD;
                        end else begin
                            bad_code_d = 1'b1;
                            fail_cnt_d = fail_inc;
                            if (fail_inc == MAX_FAIL_V) begin
                                state_d = ST_LOCKOUT;
                                alarm_d = 1'b1;
                                timer_d = LOCK_LOAD;
                            end
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        mis_d     = mis_now;
                    end
                end
            end
            ST_OPEN: begin
                if (clear || timer_q == '0) begin
                    state_d    = ST_ENTER;
                    unlocked_d = 1'b0;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d    = ST_ENTER;
                    alarm_d    = 1'b0;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d    = ST_ENTER;
                unlocked_d = 1'b0;
                alarm_d    = 1'b0;
                timer_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ENTER;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            bad_code_q <= 1'b0;
            fail_cnt_q <= '0;
            bit_idx_q  <= '0;
            mis_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
            bad_code_q <= bad_code_d;
            fail_cnt_q <= fail_cnt_d;
            bit_idx_q  <= bit_idx_d;
            mis_q      <= mis_d;
            timer_q    <= timer_d;
        end
    end

    assign unlocked = unlocked_q;
    assign alarm    = alarm_q;
    assign bad_code = bad_code_q;
    assign fail_cnt = fail_cnt_q;
    assign bit_idx  = bit_idx_q;

endmodule

// File: tb/tb_seq_code_lock.sv
// Bench for seq_code_lock: a default-parameter lock is checked every cycle against a
// behavioural model, and an 8-bit, single-failure variant is checked with directed expectations.
module tb_seq_code_lock;

  localparam logic [3:0] CODE1 = 4'b0110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: default parameters.
  logic rst = 1'b1, bit_valid = 1'b0, bit_in = 1'b0, clear = 1'b0;
  logic unlocked, alarm, bad_code;
  logic [1:0] fail_cnt;
  logic [2:0] bit_idx;

  seq_code_lock dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear(clear),
    .unlocked(unlocked), .alarm(alarm), .bad_code(bad_code),
    .fail_cnt(fail_cnt), .bit_idx(bit_idx)
  );

  // Instance 2: 8-bit code, immediate lockout, one-cycle open window.
  logic rst2 = 1'b1, bit_valid2 = 1'b0, bit_in2 = 1'b0, clear2 = 1'b0;
  logic unlocked2, alarm2, bad_code2;
  logic [0:0] fail_cnt2;
  logic [3:0] bit_idx2;

  seq_code_lock #(
    .CODE_LEN(8), .CODE(8'hA5), .MAX_FAIL(1), .LOCKOUT_CYC(16), .UNLOCK_CYC(1)
  ) dut2 (
    .clk(clk), .rst(rst2), .bit_valid(bit_valid2), .bit_in(bit_in2), .clear(clear2),
    .unlocked(unlocked2), .alarm(alarm2), .bad_code(bad_code2),
    .fail_cnt(fail_cnt2), .bit_idx(bit_idx2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: remaining open/alarm cycles, failure count, and bits entered so far.
  int   m_open  = 0;
  int   m_lock  = 0;
  int   m_fails = 0;
  logic m_bad   = 1'b0;
  int   m_entry[$];

  int hi_unl = 0;
  int hi_alm = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic b, input logic c);
    int val;
    m_bad = 1'b0;
    if (r) begin
      m_open = 0; m_lock = 0; m_fails = 0; m_entry.delete();
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_open > 0) begin
      if (c) m_open = 0;
      else   m_open--;
    end else if (c) begin
      m_entry.delete();
    end else if (v) begin
      m_entry.push_back(int'(b));
      if (m_entry.size() == 4) begin
        val = 0;
        foreach (m_entry[i]) val = val * 2 + m_entry[i];
        if (val == int'(CODE1)) begin
          m_open  = 8;
          m_fails = 0;
        end else begin
          m_bad = 1'b1;
          if (m_fails < 3) m_fails++;
          if (m_fails == 3) m_lock = 16;
        end
        m_entry.delete();
      end
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic b, input logic c);
    rst = r; bit_valid = v; bit_in = b; clear = c;
    @(posedge clk);
    model_step(r, v, b, c);
    #1;
    chk("unlocked", 32'(unlocked), 32'(m_open > 0));
    chk("alarm",    32'(alarm),    32'(m_lock > 0));
    chk("bad_code", 32'(bad_code), 32'(m_bad));
    chk("fail_cnt", 32'(fail_cnt), 32'(m_fails));
    chk("bit_idx",  32'(bit_idx),  32'(m_entry.size()));
    chk("exclusive", 32'(unlocked & alarm), 32'd0);
    if (unlocked === 1'b1) hi_unl++;
    if (alarm === 1'b1)    hi_alm++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter(input logic [3:0] code);
    for (int i = 3; i >= 0; i--) cycle(1'b0, 1'b1, code[i], 1'b0);
  endtask

  task automatic cycle2(input logic r, input logic v, input logic b, input logic c,
                        input logic e_unl, input logic e_alm, input logic e_bad,
                        input int e_fail, input int e_idx);
    rst2 = r; bit_valid2 = v; bit_in2 = b; clear2 = c;
    @(posedge clk);
    #1;
    chk("p8_unlocked", 32'(unlocked2), 32'(e_unl));
    chk("p8_alarm",    32'(alarm2),    32'(e_alm));
    chk("p8_bad_code", 32'(bad_code2), 32'(e_bad));
    chk("p8_fail_cnt", 32'(fail_cnt2), 32'(e_fail));
    chk("p8_bit_idx",  32'(bit_idx2),  32'(e_idx));
  endtask

  initial begin
    logic [7:0] code8;
    int mode;
    logic [3:0] att;

    // 1. Reset, then correct code; open window length.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    hi_unl = 0; hi_alm = 0;
    enter(4'b0110);
    idle(10);
    chk("t1_open_len", 32'(hi_unl), 32'd8);
    chk("t1_alarm_len", 32'(hi_alm), 32'd0);

    // 2. Wrong code, then correct code.
    enter(4'b0111);
    idle(1);
    enter(4'b0110);
    idle(9);

    // 3. Lockout; correct code during lockout is ignored.
    hi_unl = 0; hi_alm = 0;
    enter(4'b1111);
    enter(4'b1111);
    enter(4'b1111);
    chk("t3_alarm_on_eval", 32'(alarm), 32'd1);
    enter(4'b0110);
    idle(13);
    chk("t3_alarm_len", 32'(hi_alm), 32'd16);
    chk("t3_no_unlock", 32'(hi_unl), 32'd0);
    enter(4'b0110);
    idle(9);

    // 4. Gapped entry, then clear together with bit_valid.
    enter(4'b0111);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    chk("t4_idx_after_clear", 32'(bit_idx), 32'd0);
    enter(4'b0110);
    idle(9);

    // 5. Early relock via clear, reset while open, reset mid-alarm.
    enter(4'b0110);
    idle(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_clear_relock", 32'(unlocked), 32'd0);
    enter(4'b0110);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_rst_open", 32'(unlocked), 32'd0);
    enter(4'b1000); enter(4'b1000); enter(4'b1000);
    idle(4);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_rst_alarm", 32'(alarm), 32'd0);
    chk("t5_rst_fail", 32'(fail_cnt), 32'd0);

    // Randomised attempts: correct code, random code, random gaps, occasional clear/reset.
    for (int a = 0; a < 300; a++) begin
      mode = $urandom_range(0, 2);
      att  = (mode == 0) ? CODE1 : 4'($urandom_range(0, 15));
      for (int i = 3; i >= 0; i--) begin
        while ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        if ($urandom_range(0, 59) == 0)       cycle(1'b0, 1'($urandom_range(0, 1)), att[i], 1'b1);
        else if ($urandom_range(0, 199) == 0) cycle(1'b1, 1'b1, att[i], 1'b0);
        else                                  cycle(1'b0, 1'b1, att[i], 1'b0);
      end
    end
    idle(20);

    // 6. 8-bit variant.
    rst = 1'b0; bit_valid = 1'b0; clear = 1'b0;
    cycle2(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    code8 = 8'hA5;
    for (int k = 0; k < 8; k++)
      cycle2(1'b0, 1'b1, code8[7-k], 1'b0, k == 7, 1'b0, 1'b0, 0, (k == 7) ? 0 : k + 1);
    cycle2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    code8 = 8'hA4;
    for (int k = 0; k < 8; k++)
      cycle2(1'b0, 1'b1, code8[7-k], 1'b0, 1'b0, k == 7, k == 7, (k == 7) ? 1 : 0,
             (k == 7) ? 0 : k + 1);
    for (int k = 0; k < 15; k++)
      cycle2(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
    cycle2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    code8 = 8'hA5;
    for (int k = 0; k < 8; k++)
      cycle2(1'b0, 1'b1, code8[7-k], 1'b0, k == 7, 1'b0, 1'b0, 0, (k == 7) ? 0 : k + 1);
    cycle2(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
